// File: rtl/img_seq_pkg.sv
// Shared types and constants for the image-load sequencer.
// Derived image geometry is computed by constant functions.
package img_seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_ISSUE,
        ST_STREAM,
        ST_WAIT_SWAP,
        ST_SHOW
    } state_t;

    localparam int SD_BLOCK_BYTES = 512;

    function automatic int img_bytes(input int w, input int h, input int bpp);
        return w * h * bpp;
    endfunction

    function automatic int nblk(input int w, input int h, input int bpp);
        return (img_bytes(w, h, bpp) + SD_BLOCK_BYTES - 1) / SD_BLOCK_BYTES;
    endfunction

    function automatic int stride(input int w, input int h, input int bpp);
        return nblk(w, h, bpp) * SD_BLOCK_BYTES;
    endfunction

endpackage

// File: rtl/image_load_sequencer_pixel_packer.sv
// Packs an SD byte stream into BPP-byte pixels (big-endian for BPP=2)
// and tracks the frame-buffer pixel index of each emitted pixel.
module pixel_packer #(
    parameter int BPP = 2,
    parameter int AW  = 17
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [7:0]       byte_data,
    input  logic             byte_valid,
    output logic [8*BPP-1:0] pixel,
    output logic             pixel_valid,
    output logic [AW-1:0]    addr
);

    logic [AW-1:0] count;

    if (BPP == 2) begin : g_two
        logic [7:0] hi;
        logic       phase;

        // Hold the first byte, emit {first, second} on the second byte
        always_ff @(posedge clk) begin
            if (!reset_n || clear) begin
                hi          <= 8'd0;
                phase       <= 1'b0;
                pixel       <= '0;
                pixel_valid <= 1'b0;
                addr        <= '0;
                count       <= '0;
            end else begin
                pixel_valid <= 1'b0;
                if (byte_valid) begin
                    if (!phase) begin
                        hi    <= byte_data;
                        phase <= 1'b1;
                    end else begin
                        phase       <= 1'b0;
                        pixel       <= {hi, byte_data};
                        pixel_valid <= 1'b1;
                        addr        <= count;
                        count       <= count + 1'b1;
                    end
                end
            end
        end
    end else begin : g_one
        // Every byte is a complete pixel
        always_ff @(posedge clk) begin
            if (!reset_n || clear) begin
                pixel       <= '0;
                pixel_valid <= 1'b0;
                addr        <= '0;
                count       <= '0;
            end else begin
                pixel_valid <= 1'b0;
                if (byte_valid) begin
                    pixel       <= byte_data;
                    pixel_valid <= 1'b1;
                    addr        <= count;
                    count       <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/image_load_sequencer.sv
// Streams images from SD into the back frame-buffer bank and swaps
// banks at frame start; handles next/prev/slideshow and load timeouts.
module image_load_sequencer
    import img_seq_pkg::*;
#(
    parameter int          IMG_W        = 320,
    parameter int          IMG_H        = 240,
    parameter int          BPP          = 2,
    parameter int          NUM_IMAGES   = 16,
    parameter logic [31:0] BASE_ADDR    = 32'd0,
    parameter int          SLIDE_FRAMES = 300,
    parameter int          TIMEOUT      = 1_000_000,
    localparam int         PIXELS       = IMG_W * IMG_H,
    localparam int         AW           = (PIXELS > 1) ? $clog2(PIXELS) : 1,
    localparam int         IW           = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             slide_en,
    input  logic             frame_start,
    input  logic             sd_busy,
    input  logic             sd_valid,
    input  logic [7:0]       sd_data,
    input  logic             sd_read_done,
    output logic             sd_start_read,
    output logic [31:0]      sd_read_addr,
    output logic             fb_we,
    output logic             fb_wbank,
    output logic [AW-1:0]    fb_waddr,
    output logic [8*BPP-1:0] fb_wdata,
    output logic             disp_bank,
    output logic [IW-1:0]    image_index,
    output logic             loading,
    output logic             load_error
);

    localparam logic [31:0] IMG_BYTES_C = 32'(img_bytes(IMG_W, IMG_H, BPP));
    localparam logic [31:0] LAST_BLK    = 32'(nblk(IMG_W, IMG_H, BPP) - 1);
    localparam logic [31:0] STRIDE_C    = 32'(stride(IMG_W, IMG_H, BPP));
    localparam logic [31:0] BLK_BYTES_C = 32'(SD_BLOCK_BYTES);
    localparam logic [31:0] TIMEOUT_C   = 32'(TIMEOUT);
    localparam logic [31:0] SLIDE_C     = 32'(SLIDE_FRAMES);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_IMAGES - 1);

    state_t        state;
    logic [IW-1:0] index;
    logic [IW-1:0] prev_index;
    logic [31:0]   blk;
    logic [31:0]   byte_cnt;
    logic [31:0]   idle_cnt;
    logic [31:0]   slide_cnt;

    logic          go_next;
    logic          go_prev;
    logic          slide_adv;
    logic          go_load;
    logic          timed_out;
    logic [IW-1:0] target_idx;
    logic          pack_valid;
    logic          pack_clear;

    assign image_index = index;
    assign fb_wbank    = ~disp_bank;

    // Decode user/slideshow actions, timeout and packer controls
    always_comb begin
        go_next    = btn_next & ~btn_prev;
        go_prev    = btn_prev & ~btn_next;
        slide_adv  = slide_en && frame_start
                     && ((slide_cnt + 32'd1) >= SLIDE_C);
        go_load    = (state == ST_SHOW) && (go_next || go_prev || slide_adv);
        target_idx = (index == LAST_IDX) ? '0 : index + 1'b1;
        if (go_prev) begin
            target_idx = (index == '0) ? LAST_IDX : index - 1'b1;
        end
        timed_out  = !sd_valid && ((idle_cnt + 32'd1) >= TIMEOUT_C);
        pack_valid = (state == ST_STREAM) && sd_valid
                     && (byte_cnt < IMG_BYTES_C);
        pack_clear = go_load || ((state == ST_INIT) && !sd_busy);
    end

    // Main sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_INIT;
            index         <= '0;
            prev_index    <= '0;
            blk           <= 32'd0;
            byte_cnt      <= 32'd0;
            idle_cnt      <= 32'd0;
            slide_cnt     <= 32'd0;
            sd_start_read <= 1'b0;
            sd_read_addr  <= 32'd0;
            disp_bank     <= 1'b0;
            loading       <= 1'b0;
            load_error    <= 1'b0;
        end else begin
            sd_start_read <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (!sd_busy) begin
                        state      <= ST_ISSUE;
                        index      <= '0;
                        prev_index <= '0;
                        blk        <= 32'd0;
                        byte_cnt   <= 32'd0;
                        loading    <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (!sd_busy) begin
                        sd_start_read <= 1'b1;
                        sd_read_addr  <= BASE_ADDR
                                         + 32'(index) * STRIDE_C
                                         + blk * BLK_BYTES_C;
                        idle_cnt      <= 32'd0;
                        state         <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (sd_valid) begin
                        byte_cnt <= byte_cnt + 32'd1;
                    end
                    if (sd_read_done) begin
                        idle_cnt <= 32'd0;
                        if (blk == LAST_BLK) begin
                            state <= ST_WAIT_SWAP;
                        end else begin
                            blk   <= blk + 32'd1;
                            state <= ST_ISSUE;
                        end
                    end else if (timed_out) begin
                        load_error <= 1'b1;
                        index      <= prev_index;
                        idle_cnt   <= 32'd0;
                        loading    <= 1'b0;
                        state      <= ST_SHOW;
                    end else if (sd_valid) begin
                        idle_cnt <= 32'd0;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                ST_WAIT_SWAP: begin
                    if (frame_start) begin
                        disp_bank  <= ~disp_bank;
                        load_error <= 1'b0;
                        loading    <= 1'b0;
                        state      <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (go_load) begin
                        prev_index <= index;
                        index      <= target_idx;
                        blk        <= 32'd0;
                        byte_cnt   <= 32'd0;
                        slide_cnt  <= 32'd0;
                        loading    <= 1'b1;
                        state      <= ST_ISSUE;
                    end else if (!slide_en) begin
                        slide_cnt <= 32'd0;
                    end else if (frame_start) begin
                        slide_cnt <= slide_cnt + 32'd1;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    pixel_packer #(
        .BPP (BPP),
        .AW  (AW)
    ) u_packer (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (pack_clear),
        .byte_data   (sd_data),
        .byte_valid  (pack_valid),
        .pixel       (fb_wdata),
        .pixel_valid (fb_we),
        .addr        (fb_waddr)
    );

endmodule

// File: tb/tb_image_load_sequencer.sv
// Directed-sequence bench with a randomized SD block model and a
// byte-stream reference for every frame-buffer write.
module tb_image_load_sequencer;

    localparam int W   = 16;
    localparam int H   = 20;
    localparam int B   = 2;
    localparam int N   = 3;
    localparam int SF  = 3;
    localparam int TO  = 50;
    localparam int PIX = W * H;
    localparam int STR = 1024;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        btn_next, btn_prev, slide_en, frame_start;
    logic        sd_busy, sd_valid, sd_read_done;
    logic [7:0]  sd_data;
    logic        sd_start_read;
    logic [31:0] sd_read_addr;
    logic        fb_we, fb_wbank;
    logic [8:0]  fb_waddr;
    logic [15:0] fb_wdata;
    logic        disp_bank;
    logic [1:0]  image_index;
    logic        loading, load_error;

    always #5 clk = ~clk;

    image_load_sequencer #(
        .IMG_W        (W),
        .IMG_H        (H),
        .BPP          (B),
        .NUM_IMAGES   (N),
        .BASE_ADDR    (32'd0),
        .SLIDE_FRAMES (SF),
        .TIMEOUT      (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_next      (btn_next),
        .btn_prev      (btn_prev),
        .slide_en      (slide_en),
        .frame_start   (frame_start),
        .sd_busy       (sd_busy),
        .sd_valid      (sd_valid),
        .sd_data       (sd_data),
        .sd_read_done  (sd_read_done),
        .sd_start_read (sd_start_read),
        .sd_read_addr  (sd_read_addr),
        .fb_we         (fb_we),
        .fb_wbank      (fb_wbank),
        .fb_waddr      (fb_waddr),
        .fb_wdata      (fb_wdata),
        .disp_bank     (disp_bank),
        .image_index   (image_index),
        .loading       (loading),
        .load_error    (load_error)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Card content: every byte is a function of its absolute address
    function automatic logic [7:0] sdbyte(input int a);
        logic [31:0] v;
        v = a;
        return v[7:0] ^ v[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [15:0] pix(input int img, input int p);
        int base;
        base = img * STR + 2 * p;
        return {sdbyte(base), sdbyte(base + 1)};
    endfunction

    // Reference state shared by model, monitor and sequence
    int          reqs[$];
    int          wr_cnt   = 0;
    int          exp_img  = 0;
    logic        exp_bank = 1'b0;
    int          stall_at = -1;
    int          sd_count = 0;
    logic        sd_abort = 1'b0;
    logic        sd_act   = 1'b0;
    logic        done_pend = 1'b0;
    int          blk_addr = 0;
    int          bi       = 0;

    // SD controller model: 512-byte blocks with random gaps
    initial begin
        sd_busy      = 1'b0;
        sd_valid     = 1'b0;
        sd_read_done = 1'b0;
        sd_data      = 8'd0;
        forever begin
            @(negedge clk);
            sd_valid     = 1'b0;
            sd_read_done = 1'b0;
            sd_data      = 8'($urandom);
            if (!reset_n || sd_abort) begin
                sd_act    = 1'b0;
                done_pend = 1'b0;
            end else if (done_pend) begin
                sd_read_done = 1'b1;
                done_pend    = 1'b0;
                sd_act       = 1'b0;
            end else if (sd_act) begin
                if (stall_at >= 0 && sd_count == stall_at) begin
                    sd_valid = 1'b0;
                end else if ($urandom_range(0, 3) != 0) begin
                    sd_valid = 1'b1;
                    sd_data  = sdbyte(blk_addr + bi);
                    bi++;
                    sd_count++;
                    if (bi == 512) begin
                        if ($urandom_range(0, 1) == 1) begin
                            sd_read_done = 1'b1;
                            sd_act       = 1'b0;
                        end else begin
                            done_pend = 1'b1;
                        end
                    end
                end
            end else if (sd_start_read) begin
                sd_act   = 1'b1;
                blk_addr = int'(sd_read_addr);
                bi       = 0;
                reqs.push_back(int'(sd_read_addr));
            end
            sd_busy = sd_act || done_pend;
        end
    end

    // Frame-buffer write monitor against the card byte stream
    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            chk("wr_addr", 32'(fb_waddr), 32'(wr_cnt));
            chk("wr_data", 32'(fb_wdata), 32'(pix(exp_img, wr_cnt)));
            chk("wr_bank", 32'(fb_wbank), {31'd0, ~exp_bank});
            wr_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic arm(input int img);
        reqs.delete();
        wr_cnt   = 0;
        exp_img  = img;
        sd_count = 0;
    endtask

    task automatic pulse_btn(input logic nx, input logic pv);
        btn_next = nx;
        btn_prev = pv;
        @(negedge clk);
        btn_next = 1'b0;
        btn_prev = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    function automatic int req_at(input int i);
        return (reqs.size() > i) ? reqs[i] : -1;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_start"}, 32'(sd_start_read), 0);
        chk({tag, "_raddr"}, sd_read_addr, 0);
        chk({tag, "_we"}, 32'(fb_we), 0);
        chk({tag, "_waddr"}, 32'(fb_waddr), 0);
        chk({tag, "_wdata"}, 32'(fb_wdata), 0);
        chk({tag, "_bank"}, 32'(disp_bank), 0);
        chk({tag, "_wbank"}, 32'(fb_wbank), 1);
        chk({tag, "_idx"}, 32'(image_index), 0);
        chk({tag, "_loading"}, 32'(loading), 0);
        chk({tag, "_err"}, 32'(load_error), 0);
    endtask

    task automatic finish_load(input string tag, input int img,
                               input logic err);
        for (int c = 0; c < 6000; c++) begin
            if (reqs.size() >= 2 && !sd_act && !done_pend && wr_cnt == PIX)
                break;
            @(negedge clk);
        end
        tick(3);
        chk({tag, "_nreq"}, 32'(reqs.size()), 2);
        chk({tag, "_addr0"}, 32'(req_at(0)), 32'(img * STR));
        chk({tag, "_addr1"}, 32'(req_at(1)), 32'(img * STR + 512));
        chk({tag, "_writes"}, 32'(wr_cnt), 32'(PIX));
        chk({tag, "_loading"}, 32'(loading), 1);
        chk({tag, "_hold"}, 32'(disp_bank), 32'(exp_bank));
        chk({tag, "_idx"}, 32'(image_index), 32'(img));
        chk({tag, "_err_pre"}, 32'(load_error), 32'(err));
        pulse_frame();
        chk({tag, "_swap"}, 32'(disp_bank), {31'd0, ~exp_bank});
        chk({tag, "_done"}, 32'(loading), 0);
        chk({tag, "_err_post"}, 32'(load_error), 0);
        exp_bank = ~exp_bank;
        tick(2);
        chk({tag, "_nopad"}, 32'(wr_cnt), 32'(PIX));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        btn_next    = 1'b0;
        btn_prev    = 1'b0;
        slide_en    = 1'b0;
        frame_start = 1'b0;
        tick(3);
        check_zero("rst");

        arm(0);
        reset_n = 1'b1;
        finish_load("load0", 0, 1'b0);

        arm(2);
        pulse_btn(1'b0, 1'b1);
        chk("prev_wrap_idx", 32'(image_index), 2);
        finish_load("wrap_prev", 2, 1'b0);

        arm(0);
        pulse_btn(1'b1, 1'b0);
        chk("next_wrap_idx", 32'(image_index), 0);
        finish_load("wrap_next", 0, 1'b0);

        reqs.delete();
        pulse_btn(1'b1, 1'b1);
        tick(4);
        chk("both_loading", 32'(loading), 0);
        chk("both_idx", 32'(image_index), 0);
        chk("both_nreq", 32'(reqs.size()), 0);

        arm(1);
        pulse_btn(1'b1, 1'b0);
        tick(20);
        pulse_btn(1'b1, 1'b0);
        tick(5);
        pulse_btn(1'b0, 1'b1);
        tick(3);
        pulse_frame();
        chk("busy_idx", 32'(image_index), 1);
        chk("busy_bank", 32'(disp_bank), 32'(exp_bank));
        finish_load("ignore", 1, 1'b0);

        arm(2);
        stall_at = 100;
        pulse_btn(1'b1, 1'b0);
        for (int c = 0; c < 3000 && loading; c++) @(negedge clk);
        chk("to_err", 32'(load_error), 1);
        chk("to_idx", 32'(image_index), 1);
        chk("to_bank", 32'(disp_bank), 32'(exp_bank));
        chk("to_loading", 32'(loading), 0);
        chk("to_writes", 32'(wr_cnt), 50);
        chk("to_nreq", 32'(reqs.size()), 1);
        stall_at = -1;
        sd_abort = 1'b1;
        tick(2);
        sd_abort = 1'b0;

        arm(2);
        pulse_btn(1'b1, 1'b0);
        tick(10);
        chk("err_held", 32'(load_error), 1);
        finish_load("recover", 2, 1'b1);

        slide_en = 1'b1;
        arm(0);
        for (int f = 0; f < SF - 1; f++) begin
            pulse_frame();
            tick(3);
            chk("slide_wait", 32'(loading), 0);
        end
        chk("slide_wait_idx", 32'(image_index), 2);
        pulse_frame();
        chk("slide_go", 32'(loading), 1);
        chk("slide_idx", 32'(image_index), 0);
        slide_en = 1'b0;
        finish_load("slide", 0, 1'b0);

        arm(1);
        pulse_btn(1'b1, 1'b0);
        for (int c = 0; c < 3000 && wr_cnt < 20; c++) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_zero("mid_rst");
        exp_bank = 1'b0;
        arm(0);
        tick(2);
        chk("rst_quiet", 32'(wr_cnt), 0);
        reset_n = 1'b1;
        finish_load("fresh", 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
